mod_div_scheduler: RTL

//  Shares one iterative repeated-subtraction modulo/divide engine between NREQ requesters.

---
 rtl/mod_div_if.sv | 31 +++
 rtl/mod_div_scheduler.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mod_div_if.sv
// Request/result bundle between NREQ requesters and the shared modulo/divide scheduler.
// Operands are packed per requester: requester i at [i*WIDTH +: WIDTH].
interface mod_div_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  result_valid;
    logic [IDW-1:0]        result_id;
    logic [WIDTH-1:0]      quotient;
    logic [WIDTH-1:0]      remainder;
    logic                  div_by_zero;

    // Requester side: presents requests and operands, consumes grant and results.
    modport master (
        output req, a_in, b_in,
        input  grant, busy, result_valid, result_id, quotient, remainder, div_by_zero
    );

    // Scheduler side.
    modport slave (
        input  req, a_in, b_in,
        output grant, busy, result_valid, result_id, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mod_div_scheduler.sv
// Round-robin scheduler sharing one repeated-subtraction divide/modulo engine
// between NREQ requesters. One operation in flight; results tagged with requester id.
module mod_div_scheduler #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic     clk,
    input  logic     reset,
    mod_div_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CHECK, COMP, SUB, DONE} state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;

    logic             found;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   next_ptr;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Pick the first requesting index at or after rr_ptr, wrapping at NREQ-1.
    // The scan stops examining candidates once a winner is found, so later
    // (non-selected) request bits never influence the outcome.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // Winner's operands and the pointer position just past the winner.
    always_comb begin
        sel_a    = bus.a_in[int'(winner)*WIDTH +: WIDTH];
        sel_b    = bus.b_in[int'(winner)*WIDTH +: WIDTH];
        next_ptr = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
    end

    // Sequencer: arbitration, operand capture, check/compare/subtract loop, result return.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the engine registers are small and feed the outputs, so they are reset
        // along with the control state; an aborted operation leaves nothing stale behind.
        if (reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            r_reg            <= '0;
            q_reg            <= '0;
            bus.grant        <= '0;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result_id    <= '0;
            bus.quotient     <= '0;
            bus.remainder    <= '0;
            bus.div_by_zero  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge register values regardless of statement order.
            bus.grant        <= '0;
            bus.result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        a_reg         <= sel_a;
                        b_reg         <= sel_b;
                        r_reg         <= sel_a;
                        q_reg         <= '0;
                        bus.grant     <= NREQ'(1) << winner;
                        bus.result_id <= winner;
                        rr_ptr        <= next_ptr;
                        bus.busy      <= 1'b1;
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    if (b_reg == '0) begin
                        bus.quotient     <= '0;
                        bus.remainder    <= a_reg;
                        bus.div_by_zero  <= 1'b1;
                        bus.result_valid <= 1'b1;
                        state            <= DONE;
                    end else begin
                        state <= COMP;
                    end
                end
                COMP: begin
                    if (r_reg < b_reg) begin
                        bus.quotient     <= q_reg;
                        bus.remainder    <= r_reg;
                        bus.div_by_zero  <= 1'b0;
                        bus.result_valid <= 1'b1;
                        state            <= DONE;
                    end else begin
                        state <= SUB;
                    end
                end
                SUB: begin
                    r_reg <= r_reg - b_reg;
                    q_reg <= q_reg + 1'b1;
                    state <= COMP;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
